video_dnn_argmax_stat: RTL and testbench

//  Parametrised successor of the DNN class post-processor. Per pixel, a pipelined comparator tree takes the argmax

---
 rtl/video_dnn_argmax_stat.sv | 251 +++++++++++++++++++++++++
 tb/tb_video_dnn_argmax_stat.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_dnn_argmax_stat.sv
`timescale 1ns/1ps
// Per-pixel argmax over NUM_CLASS scores with a pipelined compare tree and reject threshold,
// plus a per-frame winner histogram whose snapshot is scanned for the dominant class.
module video_dnn_argmax_stat #(
   parameter int NUM_CLASS     = 10,
   parameter int CHANNEL_WIDTH = 8,
   parameter int TUSER_WIDTH   = 1,
   parameter int TNUMBER_WIDTH = 4,
   parameter int STAT_WIDTH    = 20,
   parameter int TDATA_WIDTH   = NUM_CLASS*CHANNEL_WIDTH
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [CHANNEL_WIDTH-1:0]         param_th,
   input  logic                             param_stat_en,
   input  logic [TUSER_WIDTH-1:0]           s_axi4s_tuser,
   input  logic                             s_axi4s_tlast,
   input  logic [TDATA_WIDTH-1:0]           s_axi4s_tdata,
   input  logic                             s_axi4s_tvalid,
   output logic                             s_axi4s_tready,
   output logic [TUSER_WIDTH-1:0]           m_axi4s_tuser,
   output logic                             m_axi4s_tlast,
   output logic [TNUMBER_WIDTH-1:0]         m_axi4s_tnumber,
   output logic [CHANNEL_WIDTH-1:0]         m_axi4s_tcount,
   output logic [TDATA_WIDTH-1:0]           m_axi4s_tdata,
   output logic                             m_axi4s_tvalid,
   input  logic                             m_axi4s_tready,
   output logic [NUM_CLASS*STAT_WIDTH-1:0]  stat_counts,
   output logic [TNUMBER_WIDTH-1:0]         stat_class,
   output logic                             stat_valid,
   output logic                             stat_overrun
);
   localparam int LVLS = $clog2(NUM_CLASS);
   localparam int CW   = CHANNEL_WIDTH;
   localparam int TNW  = TNUMBER_WIDTH;
   localparam int SW   = STAT_WIDTH;

   logic cke;
   assign cke            = !m_axi4s_tvalid || m_axi4s_tready;
   assign s_axi4s_tready = cke;

   for (genvar l = 1; l <= LVLS; l++) begin : g_lvl
      localparam int NP = (NUM_CLASS + (1 << (l-1)) - 1) >> (l-1);
      localparam int NC = (NUM_CLASS + (1 << l) - 1) >> l;
      logic [CW-1:0]          in_sc [NP];
      logic [TNW-1:0]         in_ix [NP];
      logic                   in_vld, in_last;
      logic [TUSER_WIDTH-1:0] in_user;
      logic [TDATA_WIDTH-1:0] in_dat;
      logic [CW-1:0]          sc_d [NC];
      logic [TNW-1:0]         ix_d [NC];
      logic [CW-1:0]          sc_q [NC];
      logic [TNW-1:0]         ix_q [NC];
      logic                   vld_q, last_q;
      logic [TUSER_WIDTH-1:0] user_q;
      logic [TDATA_WIDTH-1:0] dat_q;

      if (l == 1) begin : g_src
         for (genvar j = 0; j < NP; j++) begin : g_ch
            assign in_sc[j] = s_axi4s_tdata[j*CW +: CW];
            assign in_ix[j] = TNW'(j);
         end
         assign in_vld  = s_axi4s_tvalid;
         assign in_last = s_axi4s_tlast;
         assign in_user = s_axi4s_tuser;
         assign in_dat  = s_axi4s_tdata;
      end else begin : g_src
         for (genvar j = 0; j < NP; j++) begin : g_ch
            assign in_sc[j] = g_lvl[l-1].sc_q[j];
            assign in_ix[j] = g_lvl[l-1].ix_q[j];
         end
         assign in_vld  = g_lvl[l-1].vld_q;
         assign in_last = g_lvl[l-1].last_q;
         assign in_user = g_lvl[l-1].user_q;
         assign in_dat  = g_lvl[l-1].dat_q;
      end

      // Left operand wins on >= so ties resolve to the lower class index.
      for (genvar k = 0; k < NC; k++) begin : g_node
         if (2*k+1 < NP) begin : g_cmp
            assign sc_d[k] = (in_sc[2*k] >= in_sc[2*k+1]) ? in_sc[2*k] : in_sc[2*k+1];
            assign ix_d[k] = (in_sc[2*k] >= in_sc[2*k+1]) ? in_ix[2*k] : in_ix[2*k+1];
         end else begin : g_pass
            assign sc_d[k] = in_sc[2*k];
            assign ix_d[k] = in_ix[2*k];
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            vld_q  <= 1'b0;
            last_q <= 1'b0;
            user_q <= '0;
            dat_q  <= '0;
            for (int k = 0; k < NC; k++) begin
               sc_q[k] <= '0;
               ix_q[k] <= '0;
            end
         end else if (cke) begin
            vld_q  <= in_vld;
            last_q <= in_last;
            user_q <= in_user;
            dat_q  <= in_dat;
            sc_q   <= sc_d;
            ix_q   <= ix_d;
         end
      end
   end

   logic [CW-1:0]          fin_sc;
   logic [TNW-1:0]         fin_ix;
   logic                   m_vld_q, m_last_q, en_q;
   logic [TUSER_WIDTH-1:0] m_user_q;
   logic [TNW-1:0]         m_num_q;
   logic [CW-1:0]          m_cnt_q;
   logic [TDATA_WIDTH-1:0] m_dat_q;

   assign fin_sc = g_lvl[LVLS].sc_q[0];
   assign fin_ix = g_lvl[LVLS].ix_q[0];

   always_ff @(posedge clk) begin
      if (reset) begin
         m_vld_q  <= 1'b0;
         m_last_q <= 1'b0;
         m_user_q <= '0;
         m_num_q  <= '0;
         m_cnt_q  <= '0;
         m_dat_q  <= '0;
         en_q     <= 1'b0;
      end else if (cke) begin
         m_vld_q  <= g_lvl[LVLS].vld_q;
         m_last_q <= g_lvl[LVLS].last_q;
         m_user_q <= g_lvl[LVLS].user_q;
         m_dat_q  <= g_lvl[LVLS].dat_q;
         m_num_q  <= (fin_sc < param_th) ? TNW'(NUM_CLASS) : fin_ix;
         m_cnt_q  <= fin_sc;
         en_q     <= param_stat_en;
      end
   end

   assign m_axi4s_tvalid  = m_vld_q;
   assign m_axi4s_tlast   = m_last_q;
   assign m_axi4s_tuser   = m_user_q;
   assign m_axi4s_tnumber = m_num_q;
   assign m_axi4s_tcount  = m_cnt_q;
   assign m_axi4s_tdata   = m_dat_q;

   // The enable travels with the beat, so it is qualified at the output handshake.
   logic          hs, snap;
   logic [SW-1:0] cnt_q [NUM_CLASS];
   logic [SW-1:0] cnt_d [NUM_CLASS];
   logic [SW-1:0] snap_q [NUM_CLASS];

   assign hs = m_vld_q && m_axi4s_tready && en_q;

   always_comb begin
      cnt_d = cnt_q;
      snap  = 1'b0;
      if (hs) begin
         if (m_user_q[0]) begin
            snap = 1'b1;
            for (int k = 0; k < NUM_CLASS; k++) cnt_d[k] = '0;
         end
         for (int k = 0; k < NUM_CLASS; k++) begin
            if (m_num_q == TNW'(k) && cnt_d[k] != {SW{1'b1}}) cnt_d[k] = cnt_d[k] + SW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < NUM_CLASS; k++) begin
            cnt_q[k]  <= '0;
            snap_q[k] <= '0;
         end
      end else begin
         cnt_q <= cnt_d;
         if (snap) snap_q <= cnt_q;
      end
   end

   for (genvar k = 0; k < NUM_CLASS; k++) begin : g_stat
      assign stat_counts[k*SW +: SW] = snap_q[k];
   end

   typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;
   state_t         state_q, state_d;
   logic [TNW-1:0] idx_q, idx_d, best_q, best_d, cls_q, cls_d;
   logic [SW-1:0]  bestv_q, bestv_d;
   logic           vld_q, vld_d, ovr_q, ovr_d;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      best_d  = best_q;
      bestv_d = bestv_q;
      cls_d   = cls_q;
      vld_d   = 1'b0;
      ovr_d   = ovr_q;
      case (state_q)
         S_SCAN: begin
            if (snap_q[idx_q] > bestv_q) begin
               best_d  = idx_q;
               bestv_d = snap_q[idx_q];
            end
            if (idx_q == TNW'(NUM_CLASS-1)) state_d = S_DONE;
            else                            idx_d   = idx_q + TNW'(1);
         end
         S_DONE: begin
            cls_d   = best_q;
            vld_d   = 1'b1;
            state_d = S_IDLE;
         end
         default: ;
      endcase
      // A fresh snapshot aborts any scan in flight; its result is never reported.
      if (snap) begin
         if (state_q != S_IDLE) ovr_d = 1'b1;
         state_d = S_SCAN;
         idx_d   = '0;
         best_d  = TNW'(NUM_CLASS);
         bestv_d = '0;
         cls_d   = cls_q;
         vld_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         best_q  <= '0;
         bestv_q <= '0;
         cls_q   <= '0;
         vld_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         best_q  <= best_d;
         bestv_q <= bestv_d;
         cls_q   <= cls_d;
         vld_q   <= vld_d;
         ovr_q   <= ovr_d;
      end
   end

   assign stat_class   = cls_q;
   assign stat_valid   = vld_q;
   assign stat_overrun = ovr_q;
endmodule

// File: tb/tb_video_dnn_argmax_stat.sv
`timescale 1ns/1ps
// Scoreboard bench for video_dnn_argmax_stat: directed pixels, frames, saturation, stalls and scan restart.
module tb_video_dnn_argmax_stat;
   localparam int NC = 10, CW = 8, TNW = 4, SW = 4, TDW = NC*CW, L = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             reset, param_stat_en, s_tlast, s_tvalid, s_tready;
   logic [CW-1:0]    param_th;
   logic [0:0]       s_tuser, m_tuser;
   logic [TDW-1:0]   s_tdata, m_tdata;
   logic             m_tlast, m_tvalid, m_tready, stat_valid, stat_overrun;
   logic [TNW-1:0]   m_tnumber, stat_class;
   logic [CW-1:0]    m_tcount;
   logic [NC*SW-1:0] stat_counts;

   video_dnn_argmax_stat #(
      .NUM_CLASS(NC), .CHANNEL_WIDTH(CW), .TUSER_WIDTH(1), .TNUMBER_WIDTH(TNW),
      .STAT_WIDTH(SW), .TDATA_WIDTH(TDW)
   ) dut (
      .clk(clk), .reset(reset), .param_th(param_th), .param_stat_en(param_stat_en),
      .s_axi4s_tuser(s_tuser), .s_axi4s_tlast(s_tlast), .s_axi4s_tdata(s_tdata),
      .s_axi4s_tvalid(s_tvalid), .s_axi4s_tready(s_tready),
      .m_axi4s_tuser(m_tuser), .m_axi4s_tlast(m_tlast), .m_axi4s_tnumber(m_tnumber),
      .m_axi4s_tcount(m_tcount), .m_axi4s_tdata(m_tdata), .m_axi4s_tvalid(m_tvalid),
      .m_axi4s_tready(m_tready), .stat_counts(stat_counts), .stat_class(stat_class),
      .stat_valid(stat_valid), .stat_overrun(stat_overrun)
   );

   typedef struct {
      logic [93:0] b;
      int          lat;
      time         tin;
   } exp_t;

   exp_t        q[$];
   logic [43:0] sq[$];
   int          total = 0, bad = 0;
   time         snap_t = 0;
   logic        rnd_mode = 1'b0;
   logic        stall_prev = 1'b0;
   logic [94:0] held = '0;

   initial begin
      m_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_tready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   always @(negedge clk) begin
      exp_t        e;
      logic [94:0] cur;
      int          lat_act;
      cur = {m_tvalid, m_tuser, m_tlast, m_tnumber, m_tcount, m_tdata};
      if (reset) begin
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            total++;
            if (cur !== held) begin
               bad++;
               $display("FAIL stall_hold act=%h req=%h", cur, held);
            end
         end
         stall_prev = m_tvalid && !m_tready;
         held       = cur;
         if (m_tvalid && m_tready) begin
            total++;
            if (q.size() == 0) begin
               bad++;
               $display("FAIL beat_unexpected act=%h", cur[93:0]);
            end else begin
               e = q.pop_front();
               if (cur[93:0] !== e.b) begin
                  bad++;
                  $display("FAIL beat act=%h req=%h", cur[93:0], e.b);
               end
               if (e.lat > 0) begin
                  total++;
                  lat_act = int'(($time + 5 - e.tin) / 10);
                  if (lat_act != e.lat) begin
                     bad++;
                     $display("FAIL latency act=%0d req=%0d", lat_act, e.lat);
                  end
               end
               if (m_tuser[0]) snap_t = $time + 5;
            end
         end
      end
   end

   always @(negedge clk) begin
      logic [43:0] se;
      int          dly;
      if (!reset && stat_valid) begin
         total++;
         if (sq.size() == 0) begin
            bad++;
            $display("FAIL stat_unexpected class=%0d counts=%h", stat_class, stat_counts);
         end else begin
            se = sq.pop_front();
            if ({stat_class, stat_counts} !== se) begin
               bad++;
               $display("FAIL stat act=%h req=%h", {stat_class, stat_counts}, se);
            end
         end
         total++;
         dly = int'(($time - 5 - snap_t) / 10);
         if (dly != NC + 1) begin
            bad++;
            $display("FAIL stat_delay act=%0d req=%0d", dly, NC + 1);
         end
      end
   end

   initial begin
      #400000;
      total++;
      bad++;
      $display("FAIL watchdog expired");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s act=%h req=%h", nm, act, req);
      end
   endtask

   function automatic logic [TDW-1:0] mk(input int base, input int k1, input int v1,
                                         input int k2, input int v2);
      logic [TDW-1:0] r;
      for (int k = 0; k < NC; k++) begin
         r[k*CW +: CW] = CW'(base);
         if (k == k1) r[k*CW +: CW] = CW'(v1);
         if (k == k2) r[k*CW +: CW] = CW'(v2);
      end
      return r;
   endfunction

   function automatic logic [NC*SW-1:0] mks(input int k1, input int v1, input int k2, input int v2,
                                            input int k3, input int v3, input int k4, input int v4);
      logic [NC*SW-1:0] r;
      r = '0;
      if (k1 >= 0) r[k1*SW +: SW] = SW'(v1);
      if (k2 >= 0) r[k2*SW +: SW] = SW'(v2);
      if (k3 >= 0) r[k3*SW +: SW] = SW'(v3);
      if (k4 >= 0) r[k4*SW +: SW] = SW'(v4);
      return r;
   endfunction

   function automatic logic [11:0] model(input logic [TDW-1:0] d, input logic [CW-1:0] th);
      logic [TNW-1:0] bi;
      logic [CW-1:0]  bv;
      bi = '0;
      bv = d[CW-1:0];
      for (int k = 1; k < NC; k++) begin
         if (d[k*CW +: CW] > bv) begin
            bi = TNW'(k);
            bv = d[k*CW +: CW];
         end
      end
      return {(bv < th) ? TNW'(NC) : bi, bv};
   endfunction

   task automatic send(input logic [TDW-1:0] d, input logic u, input logic last,
                       input int num, input int cnt, input int lat);
      exp_t e;
      int   n;
      #1;
      s_tdata  = d;
      s_tuser  = u;
      s_tlast  = last;
      s_tvalid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s_tready && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) begin
         total++;
         bad++;
         $display("FAIL send_timeout act=0 req=1");
      end
      @(posedge clk);
      e.b   = {u, last, TNW'(num), CW'(cnt), d};
      e.lat = lat;
      e.tin = $time;
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      #1;
      s_tvalid = 1'b0;
      s_tuser  = 1'b0;
      repeat (n) @(posedge clk);
   endtask

   initial begin
      logic [TDW-1:0] d;
      logic [11:0]    m;
      int             n;
      reset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; s_tuser = 1'b0; s_tlast = 1'b0;
      param_th = 8'd127; param_stat_en = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst_s_tready", 64'(s_tready), 64'd1);
      chk("rst_stat", 64'({stat_valid, stat_overrun, stat_class, stat_counts}), 64'd0);
      @(posedge clk);

      // single pixels: latency, tie, reject, pass-through node, threshold edges
      send(mk(10, 3, 200, -1, 0), 1'b0, 1'b0, 3, 200, L);
      send(mk(0, 2, 150, 7, 150), 1'b0, 1'b0, 2, 150, 0);
      send(mk(100, -1, 0, -1, 0), 1'b0, 1'b0, 10, 100, 0);
      send(mk(10, 9, 255, -1, 0), 1'b0, 1'b0, 9, 255, 0);
      send(mk(0, 0, 127, -1, 0), 1'b0, 1'b1, 0, 127, 0);
      send(mk(0, 8, 126, -1, 0), 1'b0, 1'b0, 10, 126, 0);
      idle(10);

      // frame of 16 beats, then the next frame start reports it
      sq.push_back({4'd0, mks(0, 1, 2, 1, 3, 1, 9, 1)});
      send(mk(10, 5, 200, -1, 0), 1'b1, 1'b0, 5, 200, 0);
      for (int i = 0; i < 15; i++) begin
         if (i < 8)       send(mk(10, 5, 200, -1, 0), 1'b0, 1'b0, 5, 200, 0);
         else if (i < 12) send(mk(10, 1, 180, -1, 0), 1'b0, 1'b0, 1, 180, 0);
         else             send(mk(50, -1, 0, -1, 0), 1'b0, 1'b1, 10, 50, 0);
      end
      sq.push_back({4'd5, mks(5, 9, 1, 4, -1, 0, -1, 0)});
      send(mk(10, 0, 200, -1, 0), 1'b1, 1'b0, 0, 200, 0);
      idle(20);

      // saturation at 15, then an all-reject frame
      for (int i = 0; i < 20; i++) send(mk(10, 0, 200, -1, 0), 1'b0, 1'b0, 0, 200, 0);
      sq.push_back({4'd0, mks(0, 15, -1, 0, -1, 0, -1, 0)});
      send(mk(5, -1, 0, -1, 0), 1'b1, 1'b0, 10, 5, 0);
      for (int i = 0; i < 12; i++) send(mk(5, -1, 0, -1, 0), 1'b0, 1'b0, 10, 5, 0);
      sq.push_back({4'd10, mks(-1, 0, -1, 0, -1, 0, -1, 0)});
      send(mk(5, -1, 0, -1, 0), 1'b1, 1'b0, 10, 5, 0);
      idle(20);
      chk("overrun_clear", 64'(stat_overrun), 64'd0);

      // random back-pressure with random scores
      rnd_mode = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         for (int k = 0; k < NC; k++) d[k*CW +: CW] = CW'($urandom_range(0, 255));
         m = model(d, param_th);
         send(d, 1'b0, (i % 16) == 15, int'(m[11:8]), int'(m[7:0]), 0);
      end
      rnd_mode = 1'b0;
      idle(30);

      // two frame starts three beats apart: only the second is reported
      send(mk(10, 4, 200, -1, 0), 1'b1, 1'b0, 4, 200, 0);
      send(mk(10, 4, 190, -1, 0), 1'b0, 1'b0, 4, 190, 0);
      send(mk(10, 6, 190, -1, 0), 1'b0, 1'b0, 6, 190, 0);
      sq.push_back({4'd4, mks(4, 2, 6, 1, -1, 0, -1, 0)});
      send(mk(10, 7, 200, -1, 0), 1'b1, 1'b0, 7, 200, 0);
      idle(20);
      chk("overrun_set", 64'(stat_overrun), 64'd1);

      // reset while a scan is in flight
      send(mk(10, 1, 200, -1, 0), 1'b1, 1'b0, 1, 200, 0);
      idle(9);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst2_overrun", 64'(stat_overrun), 64'd0);
      chk("rst2_m_tvalid", 64'(m_tvalid), 64'd0);
      chk("rst2_stat", 64'({stat_class, stat_counts}), 64'd0);
      repeat (25) @(posedge clk);

      n = 0;
      while ((q.size() != 0 || sq.size() != 0) && n < 200) begin
         @(posedge clk);
         n++;
      end
      chk("beats_left", 64'(q.size()), 64'd0);
      chk("stats_left", 64'(sq.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
